// File: rtl/pc_fetch_unit.sv
// Instruction fetch front end: owns the PC, issues one memory request at a time
// and presents each fetched word to decode until it is accepted or redirected.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] next_pc,
    input  logic        pc_load,
    input  logic        stall,
    input  logic        halt,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        decode_ready,
    output logic [31:0] pc_out
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic        discard;

    assign pc_out = pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            discard     <= 1'b0;
            imem_req    <= 1'b0;
            imem_addr   <= 32'h0000_0000;
            instr_out   <= 32'h0000_0000;
            instr_pc    <= 32'h0000_0000;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (halt) begin
                        state <= HALT;
                    end else if (pc_load) begin
                        pc <= next_pc;
                    end else if (!stall) begin
                        imem_req  <= 1'b1;
                        imem_addr <= pc;
                        state     <= WAIT;
                    end
                end

                // A redirect while a request is in flight cannot cancel it; the
                // discard flag drops its data once the memory finally answers.
                WAIT: begin
                    if (pc_load) begin
                        pc <= next_pc;
                        if (imem_ack) begin
                            imem_req <= 1'b0;
                            discard  <= 1'b0;
                            state    <= FETCH;
                        end else begin
                            discard <= 1'b1;
                        end
                    end else if (imem_ack) begin
                        imem_req <= 1'b0;
                        if (discard) begin
                            discard <= 1'b0;
                            state   <= FETCH;
                        end else begin
                            instr_out   <= imem_data;
                            instr_pc    <= imem_addr;
                            instr_valid <= 1'b1;
                            pc          <= pc + 32'd1;
                            state       <= HOLD;
                        end
                    end
                end

                HOLD: begin
                    if (pc_load) begin
                        pc          <= next_pc;
                        instr_valid <= 1'b0;
                        state       <= FETCH;
                    end else if (decode_ready) begin
                        instr_valid <= 1'b0;
                        state       <= FETCH;
                    end
                end

                HALT: begin
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end

                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule
